// File: rtl/best_move_selector.sv
// Picks the highest-scoring candidate move from a stream of gain beats, with early exit when all clauses are satisfied.
// Optional macro RANDOM_TIE_BREAK_EN: an 8-bit LFSR breaks ties instead of keeping the first-seen candidate.
module best_move_selector #(
  parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX = 2,
  parameter int MAXIMUM_BIT_WIDTH_OF_MOVE_INDEX    = 3,
  localparam int C = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX,
  localparam int M = MAXIMUM_BIT_WIDTH_OF_MOVE_INDEX,
  localparam int G = C + 1
) (
  input  logic         in_clk,
  input  logic         in_reset,
  input  logic         in_start,
  input  logic [M:0]   in_candidate_count,
  input  logic [G-1:0] in_current_satisfied,
  input  logic         in_gain_valid,
  input  logic [M-1:0] in_move_index,
  input  logic [G-1:0] in_number_of_satisfied_clauses,
  output logic         out_gain_ready,
  output logic         out_done,
  output logic [M-1:0] out_best_move_index,
  output logic [G-1:0] out_best_number_of_satisfied_clauses,
  output logic         out_improved,
  output logic         out_solution_found
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [G-1:0] ALL_CLAUSES = {1'b1, {C{1'b0}}};

  state_t       state_q;
  logic [M:0]   beatCount_q;
  logic [M:0]   beatCount_d;
  logic [M:0]   count_q;
  logic [G-1:0] baseline_q;
  logic [M-1:0] bestIndex_q;
  logic [G-1:0] bestScore_q;
  logic         improved_q;
  logic         solution_q;
  logic         done_q;

  logic beatAccept;
  logic firstBeat;
  logic lastBeat;
  logic isSolution;
  logic isTie;
  logic tieWin;
  logic takeGain;

`ifdef RANDOM_TIE_BREAK_EN
  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, free-running so tie outcomes depend on cycle position.
  logic [7:0] lfsr_q;

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      lfsr_q <= 8'h01;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign tieWin = lfsr_q[0];
`else
  assign tieWin = 1'b0;
`endif

  // Ready is withheld once the latched count is exhausted, which also covers empty rounds.
  assign out_gain_ready = (state_q == COLLECT) && (beatCount_q < count_q);
  assign beatAccept     = in_gain_valid && out_gain_ready;
  assign beatCount_d    = beatCount_q + 1'b1;
  assign firstBeat      = (beatCount_q == '0);
  assign lastBeat       = (beatCount_d == count_q);
  assign isSolution     = (in_number_of_satisfied_clauses >= ALL_CLAUSES);
  assign isTie          = (in_number_of_satisfied_clauses == bestScore_q) && !firstBeat;
  assign takeGain       = firstBeat || isSolution
                        || (in_number_of_satisfied_clauses > bestScore_q)
                        || (isTie && tieWin);

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q     <= IDLE;
      beatCount_q <= '0;
      count_q     <= '0;
      baseline_q  <= '0;
      bestIndex_q <= '0;
      bestScore_q <= '0;
      improved_q  <= 1'b0;
      solution_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, COLLECT: begin
          if (in_start) begin
            state_q     <= COLLECT;
            beatCount_q <= '0;
            count_q     <= in_candidate_count;
            baseline_q  <= in_current_satisfied;
            bestIndex_q <= '0;
            bestScore_q <= '0;
            improved_q  <= 1'b0;
            solution_q  <= 1'b0;
          end else if (state_q == COLLECT) begin
            if (count_q == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (beatAccept) begin
              beatCount_q <= beatCount_d;
              if (takeGain) begin
                bestIndex_q <= in_move_index;
                bestScore_q <= in_number_of_satisfied_clauses;
                improved_q  <= (in_number_of_satisfied_clauses > baseline_q);
                solution_q  <= isSolution;
              end
              if (isSolution || lastBeat) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_done                             = done_q;
  assign out_best_move_index                  = bestIndex_q;
  assign out_best_number_of_satisfied_clauses = bestScore_q;
  assign out_improved                         = improved_q;
  assign out_solution_found                   = solution_q;

endmodule
